// File: rtl/ntsc_field_gen.sv
// NTSC composite field generator: equalisation, serrated vsync, blanking and active lines
// with optional interlace, AXIS pixel slots, underflow/SOF monitoring and a scaled colour burst.
`timescale 1ns/1ps
module ntsc_field_gen #(
  parameter int CLK_PERIOD_NS = 4,
  parameter int DATA_WIDTH    = 16,
  parameter int ACTIVE_WIDTH  = 720,
  parameter int ACTIVE_LINES  = 240,
  parameter int VBLANK_LINES  = 11,
  parameter bit INTERLACE     = 1'b1,
  parameter int BLANK_LEVEL   = 77,
  parameter int BURST_SHIFT   = 1
) (
  input  logic                  s00_axis_aclk,
  input  logic                  s00_axis_aresetn,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] s00_axis_tdata,
  input  logic                  s00_axis_tvalid,
  input  logic                  s00_axis_tuser,
  output logic                  s00_axis_tready,
  input  logic [DATA_WIDTH-1:0] burst_in,
  output logic [DATA_WIDTH-1:0] m00_axis_tdata,
  output logic                  m00_axis_tvalid,
  input  logic                  m00_axis_tready,
  output logic                  m00_axis_tlast,
  output logic                  m00_axis_tuser,
  output logic                  field_out,
  output logic                  underflow,
  output logic                  sof_err,
  output logic [2:0]            state_dbg
);

  localparam int DW       = DATA_WIDTH;
  localparam int SYNC_N   = 4700 / CLK_PERIOD_NS;
  localparam int BP1_N    = 500 / CLK_PERIOD_NS;
  localparam int BURST_N  = 2500 / CLK_PERIOD_NS;
  localparam int BP2_N    = 1700 / CLK_PERIOD_NS;
  localparam int VIS_N    = 52600 / CLK_PERIOD_NS;
  localparam int LINE_N   = 63500 / CLK_PERIOD_NS;
  localparam int HALF_N   = 31750 / CLK_PERIOD_NS;
  localparam int EQP_N    = 2350 / CLK_PERIOD_NS;
  localparam int PIX_N    = VIS_N / ACTIVE_WIDTH;

  localparam int CW = $clog2(LINE_N + 1);
  localparam int LW = $clog2(ACTIVE_LINES + VBLANK_LINES + 4);
  localparam int SW = $clog2(ACTIVE_WIDTH + 1);
  localparam int PW = $clog2(PIX_N + 1);

  localparam logic [CW-1:0] C_SYNC_END  = CW'(SYNC_N);
  localparam logic [CW-1:0] C_BP1_END   = CW'(SYNC_N + BP1_N);
  localparam logic [CW-1:0] C_BURST_END = CW'(SYNC_N + BP1_N + BURST_N);
  localparam logic [CW-1:0] C_BP2_END   = CW'(SYNC_N + BP1_N + BURST_N + BP2_N);
  localparam logic [CW-1:0] C_VIS_END   = CW'(SYNC_N + BP1_N + BURST_N + BP2_N + VIS_N);
  localparam logic [CW-1:0] C_LINE_LAST = CW'(LINE_N - 1);
  localparam logic [CW-1:0] C_HALF_LAST = CW'(HALF_N - 1);
  localparam logic [CW-1:0] C_EQP       = CW'(EQP_N);
  localparam logic [CW-1:0] C_VS_LOW    = CW'(HALF_N - SYNC_N);
  localparam logic [LW-1:0] L_EQ_LAST   = LW'(2);
  localparam logic [LW-1:0] L_ACT_LAST  = LW'(ACTIVE_LINES - 1);
  localparam logic [LW-1:0] L_VB_LAST   = LW'(VBLANK_LINES - 1);
  localparam logic [SW-1:0] S_WIDTH     = SW'(ACTIVE_WIDTH);
  localparam logic [PW-1:0] P_LAST      = PW'(PIX_N - 1);
  localparam logic [DW-1:0] BLANK_V     = DW'(BLANK_LEVEL);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRE_EQ  = 3'd1,
    S_VSYNC   = 3'd2,
    S_POST_EQ = 3'd3,
    S_BLANK   = 3'd4,
    S_ACTIVE  = 3'd5
  } state_t;

  state_t          state;
  logic [CW-1:0]   cyc;
  logic            half;
  logic [LW-1:0]   line;
  logic [SW-1:0]   slot;
  logic [PW-1:0]   pix;
  logic [DW-1:0]   pix_hold;
  logic            field;

  logic            advance;
  logic            half_end;
  logic            line_end;
  logic            in_vis;
  logic            slot_start;
  logic            first_slot;
  logic            take;
  logic [DW-1:0]   sample_d;
  logic            last_d;
  logic            sof_d;
  logic [LW-1:0]   blank_last;
  logic [DW-1:0]   burst_v;
  logic signed [DW+1:0] burst_ext;
  logic signed [DW+1:0] burst_sum;

  // Handshakes: a beat moves on a clock edge where valid && ready. The output
  // stream may only move when the register is empty or the sink is ready, and
  // that same condition gates the entire timebase; the pixel source is offered
  // ready only on a slot's first cycle and only while the timebase can move.
  assign advance         = !m00_axis_tvalid || m00_axis_tready;
  assign s00_axis_tready = slot_start && advance;
  assign take            = s00_axis_tready && s00_axis_tvalid;
  assign state_dbg       = state;

  assign half_end   = (cyc == C_HALF_LAST);
  assign line_end   = (cyc == C_LINE_LAST);
  assign first_slot = (line == '0) && (slot == '0);
  assign blank_last = (INTERLACE && field) ? L_VB_LAST + LW'(1) : L_VB_LAST;

  // Burst is computed two bits wider so the offset sum cannot wrap before clamping.
  always_comb begin
    burst_ext = signed'({{2{burst_in[DW-1]}}, burst_in}) >>> BURST_SHIFT;
    burst_sum = burst_ext + signed'({2'b00, BLANK_V});
    if (burst_sum[DW+1])
      burst_v = '0;
    else if (burst_sum[DW])
      burst_v = '1;
    else
      burst_v = burst_sum[DW-1:0];
  end

  always_comb begin
    sample_d   = BLANK_V;
    last_d     = 1'b0;
    sof_d      = 1'b0;
    in_vis     = 1'b0;
    slot_start = 1'b0;
    case (state)
      S_IDLE: sample_d = '0;
      S_PRE_EQ, S_POST_EQ: begin
        if (cyc < C_EQP) sample_d = '0;
        last_d = half_end;
        sof_d  = (state == S_PRE_EQ) && (line == '0) && !half && (cyc == '0);
      end
      S_VSYNC: begin
        if (cyc < C_VS_LOW) sample_d = '0;
        last_d = half_end;
      end
      S_BLANK: begin
        if (cyc < C_SYNC_END) sample_d = '0;
        last_d = line_end;
      end
      S_ACTIVE: begin
        last_d = line_end;
        if (cyc < C_SYNC_END)
          sample_d = '0;
        else if (cyc >= C_BP1_END && cyc < C_BURST_END)
          sample_d = burst_v;
        else if (cyc >= C_BP2_END && cyc < C_VIS_END) begin
          in_vis = 1'b1;
          if (slot < S_WIDTH) begin
            if (pix == '0) begin
              slot_start = 1'b1;
              sample_d   = s00_axis_tvalid ? s00_axis_tdata : BLANK_V;
            end else begin
              sample_d = pix_hold;
            end
          end
        end
      end
      default: sample_d = '0;
    endcase
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      state           <= S_IDLE;
      cyc             <= '0;
      half            <= 1'b0;
      line            <= '0;
      slot            <= '0;
      pix             <= '0;
      pix_hold        <= '0;
      field           <= 1'b0;
      m00_axis_tdata  <= '0;
      m00_axis_tvalid <= 1'b0;
      m00_axis_tlast  <= 1'b0;
      m00_axis_tuser  <= 1'b0;
      field_out       <= 1'b0;
      underflow       <= 1'b0;
      sof_err         <= 1'b0;
    end else if (advance) begin
      m00_axis_tvalid <= (state != S_IDLE);
      m00_axis_tdata  <= sample_d;
      m00_axis_tlast  <= last_d;
      m00_axis_tuser  <= sof_d;
      field_out       <= field;

      // A missed slot shows black for its whole width; the source is never caught up.
      if (slot_start) begin
        pix_hold <= take ? s00_axis_tdata : BLANK_V;
        if (!take) underflow <= 1'b1;
        if (take && (first_slot ? !s00_axis_tuser : s00_axis_tuser)) sof_err <= 1'b1;
      end
      if (in_vis && slot < S_WIDTH) begin
        if (pix == P_LAST) begin
          pix  <= '0;
          slot <= slot + SW'(1);
        end else begin
          pix <= pix + PW'(1);
        end
      end

      case (state)
        S_IDLE: begin
          if (enable) begin
            state <= S_PRE_EQ;
            cyc   <= '0;
            half  <= 1'b0;
            line  <= '0;
          end
        end
        S_PRE_EQ, S_VSYNC, S_POST_EQ: begin
          if (half_end) begin
            cyc  <= '0;
            half <= ~half;
            if (half) begin
              if (line == L_EQ_LAST) begin
                line <= '0;
                case (state)
                  S_PRE_EQ: state <= S_VSYNC;
                  S_VSYNC:  state <= S_POST_EQ;
                  default:  state <= S_BLANK;
                endcase
              end else begin
                line <= line + LW'(1);
              end
            end
          end else begin
            cyc <= cyc + CW'(1);
          end
        end
        S_BLANK: begin
          if (line_end) begin
            cyc <= '0;
            if (line == blank_last) begin
              line  <= '0;
              state <= S_ACTIVE;
            end else begin
              line <= line + LW'(1);
            end
          end else begin
            cyc <= cyc + CW'(1);
          end
        end
        S_ACTIVE: begin
          if (line_end) begin
            cyc  <= '0;
            slot <= '0;
            pix  <= '0;
            if (line == L_ACT_LAST) begin
              line  <= '0;
              half  <= 1'b0;
              field <= INTERLACE ? ~field : 1'b0;
              state <= enable ? S_PRE_EQ : S_IDLE;
            end else begin
              line <= line + LW'(1);
            end
          end else begin
            cyc <= cyc + CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
